// File: rtl/count_pkg.sv
// count_pkg: shared compare-mode and scan-state encodings for the count_match engines.
package count_pkg;
    typedef enum logic [1:0] {
        CMP_EQ = 2'b00,
        CMP_NE = 2'b01,
        CMP_LT = 2'b10,
        CMP_GT = 2'b11
    } cmp_mode_e;
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SCAN  = 2'b01,
        DRAIN = 2'b10,
        DONE  = 2'b11
    } scan_state_e;
endpackage

// File: rtl/count_match_cmp.sv
// count_match_cmp: combinational unsigned WIDTH-bit data-vs-key comparator with selectable mode.
module count_match_cmp
    import count_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic [WIDTH-1:0] i_key,
    input  cmp_mode_e        i_mode,
    output logic             o_match
);
    assign o_match = (i_mode == CMP_EQ) ? (i_data == i_key) :
                     (i_mode == CMP_NE) ? (i_data != i_key) :
                     (i_mode == CMP_LT) ? (i_data <  i_key) :
                                          (i_data >  i_key);
endmodule

// File: rtl/count_match_scan.sv
// count_match_scan: scans DEPTH memory words and counts those matching a key under a selectable mode.
// Define COUNT_FIRST_HIT_EN to add the first-match index/hit outputs.
module count_match_scan
    import count_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int DEPTH  = 256,
    parameter  int RD_LAT = 0,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_go,
    input  logic [WIDTH-1:0] i_key,
    input  logic [1:0]       i_mode,
    output logic [AW-1:0]    o_addr,
    input  logic [WIDTH-1:0] i_rd_data,
    output logic             o_busy,
    output logic             o_done,
`ifdef COUNT_FIRST_HIT_EN
    output logic [AW-1:0]    o_first_idx,
    output logic             o_hit,
`endif
    output logic [CW-1:0]    o_count
);
    scan_state_e      r_state, w_next;
    logic [WIDTH-1:0] r_key;
    cmp_mode_e        r_mode;
    logic [AW-1:0]    r_addr;
    logic [CW-1:0]    r_count;
    logic             r_busy, r_done;
    logic             w_start, w_last, w_match, w_ev_v;
`ifdef COUNT_FIRST_HIT_EN
    logic [AW-1:0]    w_ev_a;
    logic [AW-1:0]    r_first;
    logic             r_hit;
`endif

    assign w_start = i_go && (r_state == IDLE || r_state == DONE);
    assign w_last  = r_addr == AW'(DEPTH - 1);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: w_next = i_go ? SCAN : r_state;
            SCAN:       w_next = w_last ? (RD_LAT == 1 ? DRAIN : DONE) : SCAN;
            DRAIN:      w_next = DONE;
            default:    w_next = IDLE;
        endcase
    end

    // Evaluation point: the read issued RD_LAT cycles ago, tagged with its address.
    generate
        if (RD_LAT == 1) begin : g_lat1
            logic r_tag_v;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_tag_v <= 1'b0;
                else r_tag_v <= r_state == SCAN;
            end
            assign w_ev_v = r_tag_v;
`ifdef COUNT_FIRST_HIT_EN
            logic [AW-1:0] r_tag_a;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_tag_a <= '0;
                else r_tag_a <= r_addr;
            end
            assign w_ev_a = r_tag_a;
`endif
        end else begin : g_lat0
            assign w_ev_v = r_state == SCAN;
`ifdef COUNT_FIRST_HIT_EN
            assign w_ev_a = r_addr;
`endif
        end
    endgenerate

    count_match_cmp #(.WIDTH(WIDTH)) u_cmp (
        .i_data  (i_rd_data),
        .i_key   (r_key),
        .i_mode  (r_mode),
        .o_match (w_match)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_key   <= '0;
            r_mode  <= CMP_EQ;
            r_addr  <= '0;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= w_next == SCAN || w_next == DRAIN;
            r_done  <= w_next == DONE;
            if (w_start) begin
                r_key  <= i_key;
                r_mode <= cmp_mode_e'(i_mode);
                r_addr <= '0;
            end else if (r_state == SCAN && !w_last) begin
                r_addr <= r_addr + 1'b1;
            end
            if (w_start) r_count <= '0;
            else if (w_ev_v && w_match) r_count <= r_count + 1'b1;
        end
    end

`ifdef COUNT_FIRST_HIT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit   <= 1'b0;
            r_first <= '0;
        end else if (w_start) begin
            r_hit   <= 1'b0;
            r_first <= '0;
        end else if (w_ev_v && w_match && !r_hit) begin
            r_hit   <= 1'b1;
            r_first <= w_ev_a;
        end
    end
    assign o_first_idx = r_first;
    assign o_hit       = r_hit;
`endif

    assign o_addr  = r_addr;
    assign o_count = r_count;
    assign o_busy  = r_busy;
    assign o_done  = r_done;
endmodule

// File: doc/count_match_scan.md
# count_match_scan

Parametrised successor to the single-mode "count entries not equal to x" engine. It scans all DEPTH words of an external read-only memory and counts the words that satisfy a selectable comparison against a key. It supports configurable data width, depth, memory read latency and four compare modes, and widens the result so that a count of DEPTH is representable. It sits between the controlling FSM/top level (go/done handshake) and a ROM or other fixed-latency read port.

## Interface
- WIDTH, 8: data and key width in bits.
- DEPTH, 256: number of words scanned, at addresses 0..DEPTH-1. Must be ≥2.
- RD_LAT, 0: memory read latency in cycles, 0 or 1. With 0, rd_data is a combinational function of addr. With 1, rd_data is registered.
- AW, $clog2(DEPTH): address width (derived).
- CW, $clog2(DEPTH+1): count width (derived).
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- go  in  1  start request, sampled on clk.
- key  in  WIDTH  compare value, latched when go is accepted.
- mode  in  2  compare mode, latched when go is accepted: 00 EQ, 01 NE, 10 LT (data < key, unsigned), 11 GT (data > key, unsigned).
- addr  out  AW  memory read address.
- rd_data  in  WIDTH  memory read data.
- busy  out  1  scan in progress.
- done  out  1  result valid. This is a level, not a pulse.
- count  out  CW  number of matching words.
- first_idx  out  AW  address of the first match. Present only with COUNT_FIRST_HIT_EN.
- hit  out  1  at least one match seen. Present only with COUNT_FIRST_HIT_EN.

## Operation
- States: IDLE, SCAN, DRAIN, DONE.
- Reset (asynchronous assert, synchronous release): state = IDLE; addr = 0, count = 0, busy = 0, done = 0, first_idx = 0, hit = 0.
- IDLE or DONE with go = 1 at a rising edge causes a start:
  - latch key and mode;
  - clear count, hit and first_idx;
  - set addr = 0 and busy = 1;
  - drop done;
  - go to SCAN.
- SCAN:
  - addr increments by 1 every cycle.
  - When addr = DEPTH-1, addr holds and the next state is DRAIN if RD_LAT = 1, or DONE if RD_LAT = 0.
- Compare pipeline:
  - The address issued in cycle t is evaluated against rd_data at the edge ending cycle t+RD_LAT.
  - A tag shift register of depth RD_LAT carries a valid bit and the address alongside each read.
  - On a valid match: count += 1. If hit = 0, set hit = 1 and first_idx = the tagged address.
- DRAIN (RD_LAT = 1 only): lasts one cycle to evaluate the last word, then goes to DONE.
- DONE: busy = 0 and done = 1. count, first_idx and hit hold until the next start or reset.
- go while busy = 1 is ignored. It has no effect on key, mode or count.
- go held high continuously restarts on every edge in DONE. done is then high for exactly 1 cycle per scan.
- Key or mode changes during a scan have no effect on the scan in progress.
- Reset during SCAN or DRAIN aborts immediately to the reset values. The partial count is discarded.
- Arithmetic: count cannot overflow, because CW holds DEPTH. All comparisons are unsigned at WIDTH bits.

## Timing
- Go accepted at edge E0. Then addr = k during cycle k+1, for k = 0..DEPTH-1.
- done = 1 and the final count are both visible after edge E(DEPTH+RD_LAT). The latency is DEPTH+RD_LAT cycles from go acceptance.
- The minimum repeat interval is DEPTH+RD_LAT+1 cycles.
- All outputs are registered except addr, which is a registered counter.

## Configuration
- COUNT_FIRST_HIT_EN defined:
  - first_idx and hit ports exist.
  - first-match capture logic is built as described above.
- COUNT_FIRST_HIT_EN undefined:
  - the ports and logic are absent;
  - count, done, busy and timing are identical.

## Structure
- Package count_pkg holds:
  - enum cmp_mode_e (CMP_EQ, CMP_NE, CMP_LT, CMP_GT);
  - enum scan_state_e (IDLE, SCAN, DRAIN, DONE);
  - the mode encodings.
- One sub-module, count_match_cmp: a purely combinational WIDTH-bit comparator with inputs data, key and mode, and output match. It is reused by future multi-channel variants.

## Test plan
- Each bench scenario is a directed test on the stated memory contents and parameters.
- **NE baseline.** ROM DEPTH = 256, WIDTH = 8, RD_LAT = 0, addr i holds i mod 16, key = 3, mode NE. Required: count = 240, done exactly 256 cycles after go is sampled.
- **Full match.** All words 0xAA, key = 0xAA, mode EQ. Required: count = 256 (9-bit, no wrap), first_idx = 0, hit = 1.
- **Latency 1.** RD_LAT = 1, ROM of DEPTH = 16 holds 0..15, key = 10. Required:
  - mode LT gives count = 10;
  - mode GT gives count = 5, first_idx = 11;
  - done arrives 17 cycles after go.
- **No match.** EQ with a key absent from the memory. Required: count = 0, hit = 0, first_idx = 0.
- **Handshake abuse.** Pulse go mid-scan and change key mid-scan. Required: count is unchanged versus the clean run; busy stays 1 until done.
- **Reset mid-scan.** Assert reset low at addr = 100. Required: all outputs go to reset values immediately. A fresh go then produces the correct full count.
